eth_tx_frame_mux: RTL

- Parametrised successor to the single-channel MMIO-to-TX-AXIS frame path. Accepts frame words from N independent MMIO write channels into per-channel circular frame buffers.
- Frames are committed on their last word only. Committed frames are arbitrated round-robin onto one AXIS TX stream that feeds the MAC FIFO.
- Runs entirely in the BP clock domain, between the MMIO decode and the async MAC FIFO.

---
 rtl/eth_tx_frame_mux.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/eth_tx_frame_mux.sv
// eth_tx_frame_mux: N-channel MMIO frame writer into per-channel circular
// buffers, with round-robin arbitration of committed frames onto one AXIS TX
// stream. Optional macro ETH_TX_FRAME_MUX_STATS_EN adds per-channel
// sent-frame counters on sent_frames_o.
module eth_tx_frame_mux #(
    parameter  int channels_p       = 2,
    parameter  int data_width_p     = 64,
    parameter  int depth_p          = 16,
    localparam int keep_width_lp    = data_width_p / 8,
    localparam int chan_id_width_lp = (channels_p > 1) ? $clog2(channels_p) : 1,
    localparam int ptr_width_lp     = $clog2(depth_p) + 1
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic                                 wr_v_i,
    input  logic [chan_id_width_lp-1:0]          wr_chan_i,
    input  logic [data_width_p-1:0]              wr_data_i,
    input  logic [keep_width_lp-1:0]             wr_keep_i,
    input  logic                                 wr_last_i,
    input  logic                                 wr_abort_i,
    output logic                                 wr_yumi_o,
    output logic [data_width_p-1:0]              tx_axis_tdata_o,
    output logic [keep_width_lp-1:0]             tx_axis_tkeep_o,
    output logic                                 tx_axis_tvalid_o,
    input  logic                                 tx_axis_tready_i,
    output logic                                 tx_axis_tlast_o,
    output logic [chan_id_width_lp-1:0]          tx_axis_tdest_o,
    output logic [channels_p*ptr_width_lp-1:0]   chan_space_o,
    output logic [channels_p*ptr_width_lp-1:0]   chan_frames_o,
    output logic [channels_p-1:0]                overflow_o,
    input  logic                                 overflow_clear_i
`ifdef ETH_TX_FRAME_MUX_STATS_EN
    ,output logic [channels_p*16-1:0]            sent_frames_o
`endif
);

    localparam int addr_width_lp = ptr_width_lp - 1;
    localparam logic [ptr_width_lp-1:0] depth_lp = ptr_width_lp'(depth_p);
    localparam logic [ptr_width_lp-1:0] one_lp   = ptr_width_lp'(1);

    typedef enum logic {IDLE, SEND} state_e;

    state_e                      state_r, state_n;
    logic [chan_id_width_lp-1:0] grant_r, grant_n;
    logic [chan_id_width_lp-1:0] last_grant_r, last_grant_n;
    logic [chan_id_width_lp-1:0] pick, cand;
    logic                        pick_v;

    logic [ptr_width_lp-1:0]  wr_ptr_r     [channels_p];
    logic [ptr_width_lp-1:0]  commit_ptr_r [channels_p];
    logic [ptr_width_lp-1:0]  rd_ptr_r     [channels_p];
    logic [ptr_width_lp-1:0]  frames_r     [channels_p];
    logic [ptr_width_lp-1:0]  used         [channels_p];

    logic [data_width_p-1:0]  mem_data_r [channels_p][depth_p];
    logic [keep_width_lp-1:0] mem_keep_r [channels_p][depth_p];
    logic [depth_p-1:0]       mem_last_r [channels_p];

    logic [channels_p-1:0] sel, full, accept, ovf_set, drop, commit, rd_inc, done;
    logic                  beat, rd_last;
    logic [keep_width_lp-1:0] rd_keep;

    // Per-channel write acceptance, abort/overflow and read-advance strobes
    always_comb begin
        for (int unsigned c = 0; c < channels_p; c++) begin
            used[c]    = wr_ptr_r[c] - rd_ptr_r[c];
            full[c]    = (used[c] == depth_lp);
            sel[c]     = (wr_chan_i == chan_id_width_lp'(c));
            accept[c]  = wr_v_i & ~wr_abort_i & sel[c] & ~full[c];
            ovf_set[c] = wr_v_i & ~wr_abort_i & sel[c] & full[c] & (frames_r[c] == '0);
            drop[c]    = (wr_v_i & wr_abort_i & sel[c]) | ovf_set[c];
            commit[c]  = accept[c] & wr_last_i;
            rd_inc[c]  = beat & (grant_r == chan_id_width_lp'(c));
            done[c]    = rd_inc[c] & rd_last;
        end
    end

    assign wr_yumi_o = |accept;

    // Flatten per-channel occupancy and frame counts onto the status buses
    always_comb begin
        chan_space_o  = '0;
        chan_frames_o = '0;
        for (int unsigned c = 0; c < channels_p; c++) begin
            chan_space_o[c*ptr_width_lp +: ptr_width_lp]  = depth_lp - used[c];
            chan_frames_o[c*ptr_width_lp +: ptr_width_lp] = frames_r[c];
        end
    end

    // Arbiter next-state, round-robin pick and AXIS read-side outputs
    always_comb begin
        state_n      = state_r;
        grant_n      = grant_r;
        last_grant_n = last_grant_r;
        pick_v       = 1'b0;
        pick         = '0;
        cand         = '0;
        for (int unsigned i = 1; i <= channels_p; i++) begin
            cand = chan_id_width_lp'((32'(last_grant_r) + i) % channels_p);
            if (!pick_v && frames_r[cand] != '0) begin
                pick_v = 1'b1;
                pick   = cand;
            end
        end
        rd_last          = mem_last_r[grant_r][rd_ptr_r[grant_r][addr_width_lp-1:0]];
        rd_keep          = mem_keep_r[grant_r][rd_ptr_r[grant_r][addr_width_lp-1:0]];
        tx_axis_tdata_o  = mem_data_r[grant_r][rd_ptr_r[grant_r][addr_width_lp-1:0]];
        tx_axis_tvalid_o = (state_r == SEND);
        tx_axis_tlast_o  = (state_r == SEND) & rd_last;
        tx_axis_tkeep_o  = rd_last ? rd_keep : '1;
        tx_axis_tdest_o  = grant_r;
        beat             = tx_axis_tvalid_o & tx_axis_tready_i;
        case (state_r)
            IDLE: begin
                if (pick_v) begin
                    state_n = SEND;
                    grant_n = pick;
                end
            end
            SEND: begin
                if (beat && rd_last) begin
                    state_n      = IDLE;
                    last_grant_n = grant_r;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Arbiter state, current grant and round-robin history
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r      <= IDLE;
            grant_r      <= '0;
            last_grant_r <= chan_id_width_lp'(channels_p - 1);
        end else begin
            state_r      <= state_n;
            grant_r      <= grant_n;
            last_grant_r <= last_grant_n;
        end
    end

    // Per-channel pointers, frame counters and sticky overflow flags
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int unsigned c = 0; c < channels_p; c++) begin
                wr_ptr_r[c]     <= '0;
                commit_ptr_r[c] <= '0;
                rd_ptr_r[c]     <= '0;
                frames_r[c]     <= '0;
                overflow_o[c]   <= 1'b0;
            end
        end else begin
            for (int unsigned c = 0; c < channels_p; c++) begin
                if (drop[c])
                    wr_ptr_r[c] <= commit_ptr_r[c];
                else if (accept[c])
                    wr_ptr_r[c] <= wr_ptr_r[c] + one_lp;
                if (commit[c])
                    commit_ptr_r[c] <= wr_ptr_r[c] + one_lp;
                if (rd_inc[c])
                    rd_ptr_r[c] <= rd_ptr_r[c] + one_lp;
                frames_r[c] <= frames_r[c] + ptr_width_lp'(commit[c]) - ptr_width_lp'(done[c]);
                if (ovf_set[c])
                    overflow_o[c] <= 1'b1;
                else if (overflow_clear_i)
                    overflow_o[c] <= 1'b0;
            end
        end
    end

    // Frame buffer storage: word, keep and last bit per slot
    always_ff @(posedge clk_i) begin
        for (int unsigned c = 0; c < channels_p; c++) begin
            if (accept[c]) begin
                mem_data_r[c][wr_ptr_r[c][addr_width_lp-1:0]] <= wr_data_i;
                mem_keep_r[c][wr_ptr_r[c][addr_width_lp-1:0]] <= wr_keep_i;
                mem_last_r[c][wr_ptr_r[c][addr_width_lp-1:0]] <= wr_last_i;
            end
        end
    end

`ifdef ETH_TX_FRAME_MUX_STATS_EN
    logic [15:0] sent_r [channels_p];

    // Wrapping count of completed frames per channel
    always_ff @(posedge clk_i) begin
        for (int unsigned c = 0; c < channels_p; c++) begin
            if (!reset_n_i)
                sent_r[c] <= '0;
            else if (done[c])
                sent_r[c] <= sent_r[c] + 16'd1;
        end
    end

    // Flatten sent-frame counters onto the stats bus
    always_comb begin
        sent_frames_o = '0;
        for (int unsigned c = 0; c < channels_p; c++)
            sent_frames_o[c*16 +: 16] = sent_r[c];
    end
`endif

endmodule
